// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle between two pipeline stages and the stage register that sits between them.
// A payload moves across a side on a rising edge where that side's valid and ready are both high.
interface pipe_stage_reg_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             stall;
    logic             flush;
    logic [1:0]       count;

    modport master (
        output in_valid, in_data, out_ready, stall, flush,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  in_valid, in_data, out_ready, stall, flush,
        output in_ready, out_valid, out_data, count
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, hazard stall, flush-to-bubble and
// an optional 2-entry skid buffer that makes in_ready a pure flop output.
module pipe_stage_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = {WIDTH{1'b0}},
    parameter int               SKID   = 1
) (
    input logic            clk,
    input logic            proc_reset,
    pipe_stage_reg_if.slave bus
);
    // The state encoding doubles as the live-entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_n;
    logic [WIDTH-1:0] main_q, main_n;
    logic [WIDTH-1:0] skid_q, skid_n;
    logic             ready_q, ready_n;
    logic             main_v, dr, pop, acc, in_ready;

    assign main_v   = (state_q != EMPTY);
    assign dr       = bus.out_ready & ~bus.stall;
    assign pop      = main_v & dr;
    assign in_ready = (SKID != 0) ? ready_q : (~main_v | dr);
    assign acc      = bus.in_valid & in_ready;

    always_comb begin
        state_n = state_q;
        main_n  = main_q;
        skid_n  = skid_q;
        if (bus.flush) begin
            state_n = EMPTY;
            main_n  = BUBBLE;
            skid_n  = BUBBLE;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (acc) begin
                        state_n = ONE;
                        main_n  = bus.in_data;
                    end
                end
                ONE: begin
                    if (acc && pop) begin
                        main_n = bus.in_data;
                    end else if (acc && (SKID != 0)) begin
                        state_n = FULL;
                        skid_n  = bus.in_data;
                    end else if (pop) begin
                        // main keeps its last payload; only the valid bit drops
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_n = ONE;
                        main_n  = skid_q;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
        ready_n = (state_n != FULL);
    end

    always_ff @(posedge clk) begin
        if (proc_reset) begin
            state_q <= EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_n;
            main_q  <= main_n;
            skid_q  <= skid_n;
            ready_q <= ready_n;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = main_v;
    assign bus.out_data  = main_q;
    assign bus.count     = state_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: drives a SKID=1 and a SKID=0 instance with the same stimulus and
// compares both against queue-based reference models every cycle.
module tb_pipe_stage_reg;
    localparam int          W   = 32;
    localparam logic [W-1:0] BUB = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic proc_reset;
    always #5 clk = ~clk;

    logic         in_valid, out_ready, stall, flush;
    logic [W-1:0] in_data;

    pipe_stage_reg_if #(.WIDTH(W)) if1 ();
    pipe_stage_reg_if #(.WIDTH(W)) if0 ();

    assign if1.in_valid  = in_valid;
    assign if1.in_data   = in_data;
    assign if1.out_ready = out_ready;
    assign if1.stall     = stall;
    assign if1.flush     = flush;
    assign if0.in_valid  = in_valid;
    assign if0.in_data   = in_data;
    assign if0.out_ready = out_ready;
    assign if0.stall     = stall;
    assign if0.flush     = flush;

    pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(1)) dut_skid1 (
        .clk(clk), .proc_reset(proc_reset), .bus(if1.slave)
    );
    pipe_stage_reg #(.WIDTH(W), .BUBBLE(BUB), .SKID(0)) dut_skid0 (
        .clk(clk), .proc_reset(proc_reset), .bus(if0.slave)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    logic [W-1:0] exp_q1[$];
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] last1 = BUB;
    logic [W-1:0] last0 = BUB;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic logic ready1();
        return exp_q1.size() < 2;
    endfunction

    function automatic logic ready0();
        return (exp_q0.size() == 0) || (out_ready && !stall);
    endfunction

    function automatic logic [W-1:0] head1();
        return (exp_q1.size() > 0) ? exp_q1[0] : last1;
    endfunction

    function automatic logic [W-1:0] head0();
        return (exp_q0.size() > 0) ? exp_q0[0] : last0;
    endfunction

    // Reference model: a FIFO of capacity 2 (SKID=1) or 1 (SKID=0) that is emptied on reset/flush.
    always @(posedge clk) begin
        logic a1, p1, a0, p0;
        if (proc_reset || flush) begin
            exp_q1.delete();
            exp_q0.delete();
            last1 = BUB;
            last0 = BUB;
            if (proc_reset) chk_en = 1'b1;
        end else begin
            a1 = in_valid && ready1();
            p1 = (exp_q1.size() > 0) && out_ready && !stall;
            a0 = in_valid && ready0();
            p0 = (exp_q0.size() > 0) && out_ready && !stall;
            if (p1) last1 = exp_q1.pop_front();
            if (a1) exp_q1.push_back(in_data);
            if (p0) last0 = exp_q0.pop_front();
            if (a0) exp_q0.push_back(in_data);
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("s1_out_valid", W'(if1.out_valid), W'(exp_q1.size() > 0));
            check("s1_out_data",  if1.out_data,      head1());
            check("s1_in_ready",  W'(if1.in_ready),  W'(ready1()));
            check("s1_count",     W'(if1.count),     W'(exp_q1.size()));
            check("s0_out_valid", W'(if0.out_valid), W'(exp_q0.size() > 0));
            check("s0_out_data",  if0.out_data,      head0());
            check("s0_in_ready",  W'(if0.in_ready),  W'(ready0()));
            check("s0_count",     W'(if0.count),     W'(exp_q0.size()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d);
        in_valid = v;
        in_data  = d;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        proc_reset = 1'b1;
        drive(1'b1, 32'hDEAD_BEEF);
        out_ready = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        tick();
        tick();
        check("rst_s1_valid", W'(if1.out_valid), '0);
        check("rst_s1_data",  if1.out_data, 32'h0000_0013);
        check("rst_s1_ready", W'(if1.in_ready), W'(1));
        check("rst_s1_count", W'(if1.count), '0);
        check("rst_s0_data",  if0.out_data, 32'h0000_0013);
        check("rst_s0_count", W'(if0.count), '0);

        proc_reset = 1'b0;
        drive(1'b1, 32'h0000_0055);
        tick();
        check("post_rst_s1_data",  if1.out_data, 32'h0000_0055);
        check("post_rst_s1_valid", W'(if1.out_valid), W'(1));
        drive(1'b0, '0);
        tick();

        // streaming at full rate
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, W'(i));
            tick();
            check("stream_s1_data",  if1.out_data, W'(i));
            check("stream_s1_count", W'(if1.count), W'(1));
            check("stream_s0_data",  if0.out_data, W'(i));
            check("stream_s0_valid", W'(if0.out_valid), W'(1));
        end
        drive(1'b0, '0);
        tick();

        // stall fill into skid, then drain in order
        stall = 1'b1;
        drive(1'b1, 32'hA);
        tick();
        check("fill_s1_a", if1.out_data, 32'hA);
        drive(1'b1, 32'hB);
        tick();
        check("fill_s1_count2", W'(if1.count), W'(2));
        check("fill_s1_ready0", W'(if1.in_ready), '0);
        drive(1'b1, 32'hC);
        tick();
        check("fill_s1_hold", if1.out_data, 32'hA);
        stall = 1'b0;
        tick();
        check("drain_s1_b", if1.out_data, 32'hB);
        check("drain_s1_ready", W'(if1.in_ready), W'(1));
        tick();
        check("drain_s1_c", if1.out_data, 32'hC);
        check("drain_s1_count", W'(if1.count), W'(1));
        drive(1'b0, '0);
        tick();
        check("drain_s1_empty", W'(if1.count), '0);

        // flush with simultaneous offer; 0xC must be dropped
        stall = 1'b1;
        drive(1'b1, 32'hA);
        tick();
        drive(1'b1, 32'hB);
        tick();
        check("flush_pre_full", W'(if1.count), W'(2));
        flush = 1'b1;
        drive(1'b1, 32'hC);
        tick();
        check("flush_s1_valid", W'(if1.out_valid), '0);
        check("flush_s1_count", W'(if1.count), '0);
        check("flush_s1_data",  if1.out_data, 32'h0000_0013);
        check("flush_s1_ready", W'(if1.in_ready), W'(1));
        check("flush_s0_data",  if0.out_data, 32'h0000_0013);
        flush = 1'b0;
        stall = 1'b0;
        drive(1'b0, '0);
        tick();
        tick();
        check("flush_no_c", W'(if1.out_valid), '0);

        // SKID=0 combinational back-pressure
        out_ready = 1'b0;
        drive(1'b1, 32'hD);
        tick();
        drive(1'b1, 32'hE);
        #1;
        check("bp_s0_ready_low", W'(if0.in_ready), '0);
        out_ready = 1'b1;
        #1;
        check("bp_s0_ready_high", W'(if0.in_ready), W'(1));
        tick();
        check("bp_s0_count", W'(if0.count), W'(1));
        check("bp_s0_data",  if0.out_data, 32'hE);
        drive(1'b0, '0);
        tick();
        tick();

        // randomized traffic with occasional flush and reset
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom);
            out_ready  = ($urandom_range(0, 3) != 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 99) < 2);
            proc_reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        proc_reset = 1'b0;
        flush      = 1'b0;
        stall      = 1'b0;
        out_ready  = 1'b1;
        drive(1'b0, '0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
